// File: rtl/classifier_pkg.sv
// Shared state encoding and frame geometry for the classifier frame loader.
package classifier_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WT,
        LOAD_BS,
        LOAD_MAT,
        START,
        WAIT,
        RESULT
    } state_t;

    localparam int MAT_BYTES = 256;
    localparam int WT_BYTES  = 96;
    localparam int BS_BYTES  = 6;
    localparam logic [3:0] CLASS_ERR = 4'hF;

endpackage

// File: rtl/classifier_frame_loader_if.sv
// Byte stream, classifier start/done and result handshake bundled as one port.
interface classifier_frame_loader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic                  params_keep;
    logic                  cls_start;
    logic                  cls_done;
    logic [3:0]            cls_max;
    logic [3:0]            res_class;
    logic                  res_error;
    logic                  res_valid;
    logic                  res_ready;

    // master = the loader, slave = stream source / classifier / result sink
    modport master (
        input  s_data, s_valid, params_keep, cls_done, cls_max, res_ready,
        output s_ready, cls_start, res_class, res_error, res_valid
    );

    modport slave (
        output s_data, s_valid, params_keep, cls_done, cls_max, res_ready,
        input  s_ready, cls_start, res_class, res_error, res_valid
    );
endinterface

// File: rtl/classifier_timeout_ctr.sv
// Clear/enable cycle counter whose terminal flag marks LIMIT counted cycles.
module classifier_timeout_ctr #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic term
);
    localparam int W = $clog2(LIMIT);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign term = (count_reg == W'(LIMIT - 1));
endmodule

// File: rtl/classifier_frame_loader.sv
// Loads a byte-serial weight/bias/feature frame into stable registers, starts the
// classifier, and returns its class index (or a timeout error) on a valid/ready port.
module classifier_frame_loader
    import classifier_pkg::*;
#(
    parameter int MATRIX_SIZE       = 16,
    parameter int DATA_WIDTH        = 8,
    parameter int CLASSIFIER_WT_CNT = WT_BYTES,
    parameter int CLASSIFIER_BS_CNT = BS_BYTES,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    classifier_frame_loader_if.master    bus,
    output logic signed [DATA_WIDTH-1:0] mat_out  [MATRIX_SIZE][MATRIX_SIZE],
    output logic signed [DATA_WIDTH-1:0] wt_out   [CLASSIFIER_WT_CNT],
    output logic signed [DATA_WIDTH-1:0] bias_out [CLASSIFIER_BS_CNT],
    output logic                         busy
);
    localparam int MAT_N  = MATRIX_SIZE * MATRIX_SIZE;
    localparam int MAT_AW = $clog2(MAT_N);
    localparam int WT_AW  = $clog2(CLASSIFIER_WT_CNT);
    localparam int BS_AW  = $clog2(CLASSIFIER_BS_CNT);
    localparam logic [8:0] WT_LAST  = 9'(CLASSIFIER_WT_CNT - 1);
    localparam logic [8:0] BS_LAST  = 9'(CLASSIFIER_BS_CNT - 1);
    localparam logic [8:0] MAT_LAST = 9'(MAT_N - 1);

    state_t     state_reg;
    logic [8:0] idx_reg;
    logic       params_ok_reg;
    logic       s_ready_reg;
    logic       cls_start_reg;
    logic       res_valid_reg;
    logic       res_error_reg;
    logic [3:0] res_class_reg;

    logic signed [DATA_WIDTH-1:0] wt_reg  [CLASSIFIER_WT_CNT];
    logic signed [DATA_WIDTH-1:0] bs_reg  [CLASSIFIER_BS_CNT];
    logic signed [DATA_WIDTH-1:0] mat_reg [MAT_N];

    logic accept;
    logic feat_sel;
    logic timeout_hit;
    logic wt_we;
    logic bs_we;
    logic mat_we;

    assign accept   = bus.s_valid & s_ready_reg;
    assign feat_sel = bus.params_keep & params_ok_reg;

    // The first byte of a frame is written from IDLE, so its target depends on the frame type.
    assign wt_we  = accept & ((state_reg == LOAD_WT)  | ((state_reg == IDLE) & ~feat_sel));
    assign bs_we  = accept &  (state_reg == LOAD_BS);
    assign mat_we = accept & ((state_reg == LOAD_MAT) | ((state_reg == IDLE) &  feat_sel));

    classifier_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_reg == START),
        .en    (state_reg == WAIT),
        .term  (timeout_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            params_ok_reg <= 1'b0;
            s_ready_reg   <= 1'b0;
            cls_start_reg <= 1'b0;
            res_valid_reg <= 1'b0;
            res_error_reg <= 1'b0;
            res_class_reg <= '0;
        end else begin
            cls_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    s_ready_reg <= 1'b1;
                    if (accept) begin
                        idx_reg   <= 9'd1;
                        state_reg <= feat_sel ? LOAD_MAT : LOAD_WT;
                    end
                end
                LOAD_WT: begin
                    if (accept) begin
                        if (idx_reg == WT_LAST) begin
                            idx_reg   <= '0;
                            state_reg <= LOAD_BS;
                        end else begin
                            idx_reg <= idx_reg + 9'd1;
                        end
                    end
                end
                LOAD_BS: begin
                    if (accept) begin
                        if (idx_reg == BS_LAST) begin
                            idx_reg       <= '0;
                            params_ok_reg <= 1'b1;
                            state_reg     <= LOAD_MAT;
                        end else begin
                            idx_reg <= idx_reg + 9'd1;
                        end
                    end
                end
                LOAD_MAT: begin
                    if (accept) begin
                        if (idx_reg == MAT_LAST) begin
                            idx_reg       <= '0;
                            s_ready_reg   <= 1'b0;
                            cls_start_reg <= 1'b1;
                            state_reg     <= START;
                        end else begin
                            idx_reg <= idx_reg + 9'd1;
                        end
                    end
                end
                START: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the terminal cycle takes priority over the timeout.
                    if (bus.cls_done) begin
                        res_class_reg <= bus.cls_max;
                        res_error_reg <= (32'(bus.cls_max) >= CLASSIFIER_BS_CNT);
                        res_valid_reg <= 1'b1;
                        state_reg     <= RESULT;
                    end else if (timeout_hit) begin
                        res_class_reg <= CLASS_ERR;
                        res_error_reg <= 1'b1;
                        res_valid_reg <= 1'b1;
                        state_reg     <= RESULT;
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_reg <= 1'b0;
                        s_ready_reg   <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CLASSIFIER_WT_CNT; i++) wt_reg[i]  <= '0;
            for (int i = 0; i < CLASSIFIER_BS_CNT; i++) bs_reg[i]  <= '0;
            for (int i = 0; i < MAT_N; i++)             mat_reg[i] <= '0;
        end else begin
            if (wt_we)  wt_reg[idx_reg[WT_AW-1:0]]   <= bus.s_data;
            if (bs_we)  bs_reg[idx_reg[BS_AW-1:0]]   <= bus.s_data;
            if (mat_we) mat_reg[idx_reg[MAT_AW-1:0]] <= bus.s_data;
        end
    end

    assign wt_out   = wt_reg;
    assign bias_out = bs_reg;

    for (genvar gi = 0; gi < MATRIX_SIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < MATRIX_SIZE; gj++) begin : g_col
            assign mat_out[gi][gj] = mat_reg[gi*MATRIX_SIZE + gj];
        end
    end

    assign bus.s_ready   = s_ready_reg;
    assign bus.cls_start = cls_start_reg;
    assign bus.res_valid = res_valid_reg;
    assign bus.res_class = res_class_reg;
    assign bus.res_error = res_error_reg;
    assign busy          = (state_reg != IDLE);
endmodule
